moving_average_n: RTL

//  Parametrised streaming moving-average filter: signed sample in, rounded mean of last 2**LOG2_DEPTH

---
 rtl/moving_average_n_if.sv | 22 ++
 rtl/moving_average_n.sv | 91 +++++++++
 2 files changed

// File: rtl/moving_average_n_if.sv
// Sample stream bundle for moving_average_n.
// It carries the input sample, the clear/valid qualifiers and the registered result with its flags.
interface moving_average_n_if #(
    parameter int DATA_W = 8
);
    logic                     clear;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_full;

    modport master (
        output clear, in_valid, in_data,
        input  out_valid, out_data, out_full
    );

    modport slave (
        input  clear, in_valid, in_data,
        output out_valid, out_data, out_full
    );
endinterface

// File: rtl/moving_average_n.sv
// Streaming moving-average filter over the last 2**LOG2_DEPTH accepted samples.
// The output is the rounded mean; rounding is half toward +inf, and the result appears one cycle after each accept.
module moving_average_n #(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 2
) (
    input  logic               system1000,
    input  logic               system1000_rst,
    moving_average_n_if.slave  bus
);
    localparam int N     = 2 ** LOG2_DEPTH;
    localparam int WP_W  = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
    localparam int CNT_W = LOG2_DEPTH + 1;
    localparam int ACC_W = DATA_W + LOG2_DEPTH;
    localparam int SUM_W = ACC_W + 1;

    localparam logic [WP_W-1:0]         WP_LAST = WP_W'(N - 1);
    localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(N);
    localparam logic signed [SUM_W-1:0] RND     = SUM_W'((2 ** LOG2_DEPTH) >> 1);

    logic signed [DATA_W-1:0] mem_q [N];
    logic signed [DATA_W-1:0] mem_d [N];
    logic [WP_W-1:0]          wp_q, wp_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_full_q, out_full_d;

    logic signed [DATA_W-1:0] old_sample;
    logic signed [ACC_W-1:0]  acc_n;
    logic signed [SUM_W-1:0]  rounded;
    logic signed [DATA_W-1:0] mean;

    // The running sum swaps the oldest slot for the new sample; an empty slot reads 0 during warm-up.
    always_comb begin
        old_sample = mem_q[wp_q];
        acc_n      = acc_q + ACC_W'(bus.in_data) - ACC_W'(old_sample);
        rounded    = SUM_W'(acc_n) + RND;
        mean       = DATA_W'(rounded >>> LOG2_DEPTH);

        mem_d       = mem_q;
        wp_d        = wp_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_full_d  = out_full_q;

        if (bus.clear) begin
            mem_d      = '{default: '0};
            wp_d       = '0;
            cnt_d      = '0;
            acc_d      = '0;
            out_data_d = '0;
            out_full_d = 1'b0;
        end else if (bus.in_valid) begin
            mem_d[wp_q] = bus.in_data;
            wp_d        = (wp_q == WP_LAST) ? '0 : wp_q + WP_W'(1);
            cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            acc_d       = acc_n;
            out_valid_d = 1'b1;
            out_data_d  = mean;
            out_full_d  = (cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            mem_q       <= '{default: '0};
            wp_q        <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_full_q  <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wp_q        <= wp_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_full_q  <= out_full_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_full  = out_full_q;
endmodule
